// File: rtl/reorder_buffer_mc_if.sv
// Allocate / writeback / commit / lookup / flush bundle around reorder_buffer_mc.
// ROB_PERF_EN adds the perf_commits / perf_flushes outputs.
interface reorder_buffer_mc_if #(
  parameter int ROB_BIT      = 4,
  parameter int NUM_WB       = 2,
  parameter int COMMIT_WIDTH = 2
);
  logic                            issue_valid;
  logic                            issue_done;
  logic [1:0]                      issue_type;
  logic [4:0]                      issue_rd;
  logic [31:0]                     issue_value;
  logic                            issue_pred;
  logic [31:0]                     issue_alt_pc;
  logic [NUM_WB-1:0]               wb_valid;
  logic [NUM_WB*ROB_BIT-1:0]       wb_id;
  logic [NUM_WB*32-1:0]            wb_value;
  logic                            full;
  logic                            empty;
  logic [ROB_BIT:0]                count;
  logic [ROB_BIT-1:0]              head_id;
  logic [ROB_BIT-1:0]              tail_id;
  logic [COMMIT_WIDTH-1:0]         commit_valid;
  logic [COMMIT_WIDTH*2-1:0]       commit_type;
  logic [COMMIT_WIDTH*5-1:0]       commit_rd;
  logic [COMMIT_WIDTH*32-1:0]      commit_value;
  logic [COMMIT_WIDTH*ROB_BIT-1:0] commit_id;
  logic [ROB_BIT-1:0]              q_id1, q_id2;
  logic                            q_rdy1, q_rdy2;
  logic [31:0]                     q_val1, q_val2;
  logic                            flush;
  logic [31:0]                     flush_pc;
`ifdef ROB_PERF_EN
  logic [31:0]                     perf_commits;
  logic [15:0]                     perf_flushes;
`endif

  modport slave (
    input  issue_valid, issue_done, issue_type, issue_rd, issue_value, issue_pred, issue_alt_pc,
    input  wb_valid, wb_id, wb_value, q_id1, q_id2,
    output full, empty, count, head_id, tail_id,
    output commit_valid, commit_type, commit_rd, commit_value, commit_id,
    output q_rdy1, q_rdy2, q_val1, q_val2, flush, flush_pc
`ifdef ROB_PERF_EN
    , output perf_commits, perf_flushes
`endif
  );

  modport master (
    output issue_valid, issue_done, issue_type, issue_rd, issue_value, issue_pred, issue_alt_pc,
    output wb_valid, wb_id, wb_value, q_id1, q_id2,
    input  full, empty, count, head_id, tail_id,
    input  commit_valid, commit_type, commit_rd, commit_value, commit_id,
    input  q_rdy1, q_rdy2, q_val1, q_val2, flush, flush_pc
`ifdef ROB_PERF_EN
    , input perf_commits, perf_flushes
`endif
  );
endinterface

// File: rtl/reorder_buffer_mc.sv
// Reorder buffer: in-order retirement of up to COMMIT_WIDTH entries/cycle, NUM_WB writeback
// channels, operand lookup bypass, mispredict flush. ROB_PERF_EN adds saturating perf counters.
module reorder_buffer_mc #(
  parameter int ROB_BIT      = 4,
  parameter int NUM_WB       = 2,
  parameter int COMMIT_WIDTH = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  reorder_buffer_mc_if.slave rob
);
  localparam int         DEPTH    = 1 << ROB_BIT;
  localparam logic [1:0] T_BRANCH = 2'd2;

  typedef logic [ROB_BIT-1:0] id_t;
  typedef logic [ROB_BIT:0]   cnt_t;
  typedef struct packed {
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic [31:0] value;
    logic        pred;
    logic [31:0] alt_pc;
  } entry_t;

  entry_t           ent_q [DEPTH];
  logic [DEPTH-1:0] busy_q, ready_q;
  id_t              head_q, tail_q;
  cnt_t             count_q;
  logic             flush_q;
  logic [31:0]      flush_pc_q;

  logic full, alloc;
  assign full  = count_q == cnt_t'(DEPTH);
  assign alloc = rdy_in && !flush_q && rob.issue_valid && !full;

  assign rob.full     = full;
  assign rob.empty    = count_q == '0;
  assign rob.count    = count_q;
  assign rob.head_id  = head_q;
  assign rob.tail_id  = tail_q;
  assign rob.flush    = flush_q;
  assign rob.flush_pc = flush_pc_q;

  id_t               wb_id  [NUM_WB];
  logic [31:0]       wb_val [NUM_WB];
  logic [NUM_WB-1:0] wb_hit;
  for (genvar k = 0; k < NUM_WB; k++) begin : g_wb
    assign wb_id[k]  = rob.wb_id[k*ROB_BIT +: ROB_BIT];
    assign wb_val[k] = rob.wb_value[k*32 +: 32];
    assign wb_hit[k] = rob.wb_valid[k] && busy_q[wb_id[k]];
  end

  id_t                     slot_id [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0] slot_ok, slot_mis, ret;
  for (genvar j = 0; j < COMMIT_WIDTH; j++) begin : g_slot
    assign slot_id[j]  = head_q + id_t'(j);
    assign slot_ok[j]  = busy_q[slot_id[j]] && ready_q[slot_id[j]];
    assign slot_mis[j] = ent_q[slot_id[j]].typ == T_BRANCH &&
                         ent_q[slot_id[j]].value[0] != ent_q[slot_id[j]].pred;
    assign rob.commit_valid[j]                    = ret[j];
    assign rob.commit_type[j*2 +: 2]              = ent_q[slot_id[j]].typ;
    assign rob.commit_rd[j*5 +: 5]                = ent_q[slot_id[j]].rd;
    assign rob.commit_value[j*32 +: 32]           = ent_q[slot_id[j]].value;
    assign rob.commit_id[j*ROB_BIT +: ROB_BIT]    = slot_id[j];
  end

  // A mispredicted branch ends the retire group; younger entries are wrong-path.
  logic        go;
  cnt_t        n_ret;
  logic        mis_ret;
  logic [31:0] mis_pc;
  always_comb begin
    ret     = '0;
    n_ret   = '0;
    mis_ret = 1'b0;
    mis_pc  = '0;
    go      = rdy_in && !flush_q;
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      ret[j] = go && slot_ok[j];
      go     = ret[j] && !slot_mis[j];
      if (ret[j]) n_ret = n_ret + cnt_t'(1);
      if (ret[j] && slot_mis[j]) begin
        mis_ret = 1'b1;
        mis_pc  = ent_q[slot_id[j]].alt_pc;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q     <= '0;
      ready_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else if (rdy_in) begin
      if (flush_q) begin
        busy_q  <= '0;
        ready_q <= '0;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        flush_q <= 1'b0;
      end else begin
        for (int k = 0; k < NUM_WB; k++)
          if (wb_hit[k]) ready_q[wb_id[k]] <= 1'b1;
        for (int j = 0; j < COMMIT_WIDTH; j++)
          if (ret[j]) begin
            busy_q[slot_id[j]]  <= 1'b0;
            ready_q[slot_id[j]] <= 1'b0;
          end
        if (alloc) begin
          busy_q[tail_q]  <= 1'b1;
          ready_q[tail_q] <= rob.issue_done;
          tail_q          <= tail_q + id_t'(1);
        end
        head_q  <= head_q + id_t'(n_ret);
        count_q <= count_q + cnt_t'(alloc) - n_ret;
        if (mis_ret) begin
          flush_q    <= 1'b1;
          flush_pc_q <= mis_pc;
        end
      end
    end
  end

  // Payload carries no reset; busy/ready qualify every read. Later channels win on a shared id.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && !flush_q) begin
      for (int k = 0; k < NUM_WB; k++)
        if (wb_hit[k]) ent_q[wb_id[k]].value <= wb_val[k];
      if (alloc)
        ent_q[tail_q] <= {rob.issue_type, rob.issue_rd, rob.issue_value,
                          rob.issue_pred, rob.issue_alt_pc};
    end
  end

  id_t         q_id  [2];
  logic [1:0]  q_rdy;
  logic [31:0] q_val [2];
  assign q_id[0]    = rob.q_id1;
  assign q_id[1]    = rob.q_id2;
  assign rob.q_rdy1 = q_rdy[0];
  assign rob.q_rdy2 = q_rdy[1];
  assign rob.q_val1 = q_val[0];
  assign rob.q_val2 = q_val[1];

  // Stored value first, then live writeback (descending scan so the lowest channel wins), then tail.
  always_comb begin
    for (int q = 0; q < 2; q++) begin
      q_rdy[q] = 1'b0;
      q_val[q] = '0;
      if (ready_q[q_id[q]]) begin
        q_rdy[q] = 1'b1;
        q_val[q] = ent_q[q_id[q]].value;
      end else if (busy_q[q_id[q]]) begin
        for (int k = NUM_WB-1; k >= 0; k--)
          if (rob.wb_valid[k] && wb_id[k] == q_id[q]) begin
            q_rdy[q] = 1'b1;
            q_val[q] = wb_val[k];
          end
      end else if (alloc && rob.issue_done && tail_q == q_id[q]) begin
        q_rdy[q] = 1'b1;
        q_val[q] = rob.issue_value;
      end
    end
  end

  always_ff @(posedge clk_in)
    if (!rst_in && rdy_in && !flush_q && rob.issue_valid && full)
      $warning("reorder_buffer_mc: issue while full ignored");

`ifdef ROB_PERF_EN
  logic [31:0] perf_commits_q;
  logic [15:0] perf_flushes_q;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      perf_commits_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      if (perf_commits_q > 32'hFFFF_FFFF - 32'(n_ret)) perf_commits_q <= 32'hFFFF_FFFF;
      else                                             perf_commits_q <= perf_commits_q + 32'(n_ret);
      if (mis_ret && perf_flushes_q != 16'hFFFF) perf_flushes_q <= perf_flushes_q + 16'd1;
    end
  end
  assign rob.perf_commits = perf_commits_q;
  assign rob.perf_flushes = perf_flushes_q;
`endif
endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Directed + random bench for reorder_buffer_mc against an in-order queue model of the ROB.
module tb_reorder_buffer_mc;
  localparam int RB = 4, NWB = 2, CW = 2, DEPTH = 16;

  logic clk = 1'b0;
  logic rst, rdy;
  always #5 clk = ~clk;

  reorder_buffer_mc_if #(.ROB_BIT(RB), .NUM_WB(NWB), .COMMIT_WIDTH(CW)) rob();
  reorder_buffer_mc #(.ROB_BIT(RB), .NUM_WB(NWB), .COMMIT_WIDTH(CW)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .rob(rob)
  );

  typedef struct {
    int          id;
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        pred;
    logic [31:0] alt;
    logic        rdy;
  } ment_t;

  ment_t       mq[$];
  int          m_head = 0, m_tail = 0;
  logic        m_flush = 1'b0;
  logic [31:0] m_fpc = '0;
  int          total = 0, bad = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] m_lookup(int id);
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].id == id) begin
        if (mq[i].rdy) return {1'b1, mq[i].val};
        for (int k = 0; k < NWB; k++)
          if (rob.wb_valid[k] && int'(rob.wb_id[k*RB +: RB]) == id)
            return {1'b1, rob.wb_value[k*32 +: 32]};
        return '0;
      end
    if (rdy && !m_flush && rob.issue_valid && rob.issue_done && mq.size() < DEPTH && id == m_tail)
      return {1'b1, rob.issue_value};
    return '0;
  endfunction

  // Compare outputs for the current cycle, then advance the model across the coming edge.
  task automatic cycle_check();
    int            n, nret;
    logic [CW-1:0] ecv;
    logic          go, mis, alloc;
    logic [31:0]   mpc;
    logic [32:0]   lq;
    n = mq.size(); nret = 0; ecv = '0; mis = 1'b0; mpc = '0;
    if (!rst) begin
      chk("count", rob.count, n);
      chk("full", rob.full, n == DEPTH);
      chk("empty", rob.empty, n == 0);
      chk("head_id", rob.head_id, m_head);
      chk("tail_id", rob.tail_id, m_tail);
      chk("flush", rob.flush, m_flush);
      if (m_flush) chk("flush_pc", rob.flush_pc, m_fpc);
      go = rdy && !m_flush;
      for (int j = 0; j < CW; j++)
        if (go && j < n && mq[j].rdy) begin
          ecv[j] = 1'b1;
          nret++;
          if (mq[j].typ == 2'd2 && mq[j].val[0] != mq[j].pred) begin
            mis = 1'b1; mpc = mq[j].alt; go = 1'b0;
          end
        end else go = 1'b0;
      chk("commit_valid", rob.commit_valid, ecv);
      for (int j = 0; j < CW; j++)
        if (ecv[j]) begin
          chk("commit_id", rob.commit_id[j*RB +: RB], mq[j].id);
          chk("commit_type", rob.commit_type[j*2 +: 2], mq[j].typ);
          chk("commit_rd", rob.commit_rd[j*5 +: 5], mq[j].rd);
          chk("commit_value", rob.commit_value[j*32 +: 32], mq[j].val);
        end
      lq = m_lookup(int'(rob.q_id1));
      chk("q_rdy1", rob.q_rdy1, lq[32]);
      if (lq[32]) chk("q_val1", rob.q_val1, lq[31:0]);
      lq = m_lookup(int'(rob.q_id2));
      chk("q_rdy2", rob.q_rdy2, lq[32]);
      if (lq[32]) chk("q_val2", rob.q_val2, lq[31:0]);
    end
    if (rst) begin
      mq.delete(); m_head = 0; m_tail = 0; m_flush = 1'b0; m_fpc = '0;
    end else if (rdy) begin
      if (m_flush) begin
        mq.delete(); m_head = 0; m_tail = 0; m_flush = 1'b0;
      end else begin
        alloc = rob.issue_valid && n < DEPTH;
        for (int k = 0; k < NWB; k++)
          if (rob.wb_valid[k])
            for (int i = 0; i < mq.size(); i++)
              if (mq[i].id == int'(rob.wb_id[k*RB +: RB])) begin
                mq[i].rdy = 1'b1;
                mq[i].val = rob.wb_value[k*32 +: 32];
              end
        repeat (nret) void'(mq.pop_front());
        m_head = (m_head + nret) % DEPTH;
        if (mis) begin m_flush = 1'b1; m_fpc = mpc; end
        if (alloc) begin
          mq.push_back('{m_tail, rob.issue_type, rob.issue_rd, rob.issue_value,
                         rob.issue_pred, rob.issue_alt_pc, rob.issue_done});
          m_tail = (m_tail + 1) % DEPTH;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rob.issue_valid = 1'b0; rob.issue_done = 1'b0; rob.issue_type = '0; rob.issue_rd = '0;
    rob.issue_value = '0; rob.issue_pred = 1'b0; rob.issue_alt_pc = '0;
    rob.wb_valid = '0; rob.wb_id = '0; rob.wb_value = '0;
  endtask

  task automatic issue(logic [1:0] t, logic d, logic [4:0] rd, logic [31:0] v, logic p, logic [31:0] alt);
    rob.issue_valid = 1'b1; rob.issue_type = t; rob.issue_done = d; rob.issue_rd = rd;
    rob.issue_value = v; rob.issue_pred = p; rob.issue_alt_pc = alt;
  endtask

  task automatic wb(int k, int id, logic [31:0] v);
    rob.wb_valid[k] = 1'b1;
    rob.wb_id[k*RB +: RB] = RB'(id);
    rob.wb_value[k*32 +: 32] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); step(); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; idle(); rob.q_id1 = '0; rob.q_id2 = '0;
    @(posedge clk); #1;
    step(); step(); rst = 1'b0;
    chk("rst_count", rob.count, 0);
    chk("rst_empty", rob.empty, 1);
    chk("rst_full", rob.full, 0);
    chk("rst_flush", rob.flush, 0);
    chk("rst_flush_pc", rob.flush_pc, 0);
    chk("rst_cv", rob.commit_valid, 0);
    chk("rst_tail", rob.tail_id, 0);

    // single completed REG retires one cycle later
    issue(2'd0, 1'b1, 5'd5, 32'h11, 1'b0, 32'h0); step(); idle();
    chk("t1_cv", rob.commit_valid, 2'b01);
    chk("t1_rd", rob.commit_rd[4:0], 5);
    chk("t1_val", rob.commit_value[31:0], 32'h11);
    step();
    chk("t1_empty", rob.empty, 1);

    // fill to DEPTH, overflow issue ignored, drain two per cycle
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin issue(2'd0, 1'b0, 5'(i), 32'(i), 1'b0, 32'h0); step(); end
    idle();
    chk("fill_full", rob.full, 1);
    chk("fill_count", rob.count, 16);
    chk("fill_tail", rob.tail_id, 0);
    issue(2'd0, 1'b1, 5'd7, 32'h77, 1'b0, 32'h0); step(); idle();
    chk("ovf_count", rob.count, 16);
    chk("ovf_tail", rob.tail_id, 0);
    for (int i = 0; i < DEPTH/2; i++) begin
      idle(); wb(0, 2*i, 32'hA0 + 32'(i)); wb(1, 2*i+1, 32'hB0 + 32'(i)); step();
    end
    idle(); step(); step();
    chk("drain_empty", rob.empty, 1);

    // dual writeback -> dual commit
    do_reset();
    issue(2'd0, 1'b0, 5'd1, 32'h0, 1'b0, 32'h0); step();
    issue(2'd0, 1'b0, 5'd2, 32'h0, 1'b0, 32'h0); step(); idle();
    wb(0, 0, 32'hC0); wb(1, 1, 32'hC1); step(); idle();
    chk("dual_cv", rob.commit_valid, 2'b11);
    chk("dual_count", rob.count, 2);
    step();
    chk("dual_after", rob.count, 0);

    // mispredicted branch blocks slot1, flushes next cycle
    do_reset();
    issue(2'd2, 1'b0, 5'd0, 32'h0, 1'b0, 32'h100); step();
    issue(2'd0, 1'b1, 5'd3, 32'h33, 1'b0, 32'h0); step(); idle();
    wb(0, 0, 32'h1); step(); idle();
    chk("br_cv", rob.commit_valid, 2'b01);
    step();
    chk("br_flush", rob.flush, 1);
    chk("br_flush_pc", rob.flush_pc, 32'h100);
    chk("br_flush_cv", rob.commit_valid, 0);
    step();
    chk("br_empty", rob.empty, 1);
    chk("br_flush_clr", rob.flush, 0);

    // lookup bypass priorities
    do_reset();
    for (int i = 0; i < 4; i++) begin issue(2'd0, 1'b0, 5'(i + 8), 32'h0, 1'b0, 32'h0); step(); end
    idle(); rob.q_id1 = 4'd3; wb(1, 3, 32'hAB); #3;
    chk("q_wb_rdy", rob.q_rdy1, 1);
    chk("q_wb_val", rob.q_val1, 32'hAB);
    step(); idle();
    rob.q_id1 = 4'd2; wb(0, 2, 32'hCD); wb(1, 2, 32'hEF); #3;
    chk("q_lowch", rob.q_val1, 32'hCD);
    step(); idle();
    rob.q_id2 = 4'd4; issue(2'd0, 1'b1, 5'd12, 32'h55, 1'b0, 32'h0); #3;
    chk("q_stored", rob.q_val1, 32'hEF);
    chk("q_tail_rdy", rob.q_rdy2, 1);
    chk("q_tail_val", rob.q_val2, 32'h55);
    step(); idle();

    // rdy_in low holds everything, including writeback
    wb(0, 0, 32'h1); step(); idle();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) wb(0, 1, 32'h9); else idle();
      #1;
      chk("hold_cv", rob.commit_valid, 0);
      chk("hold_count", rob.count, 5);
      step();
    end
    rdy = 1'b1; idle(); #1;
    chk("resume_cv", rob.commit_valid, 2'b01);
    step();

    // random traffic with a mid-run reset
    for (int c = 0; c < 800; c++) begin
      int r;
      idle();
      rdy = ($urandom_range(9) != 0);
      rst = (c == 400);
      if ($urandom_range(99) < 55) begin
        r = $urandom_range(9);
        issue((r < 6) ? 2'd0 : (r == 6) ? 2'd1 : (r == 7) ? 2'd3 : 2'd2,
              1'($urandom_range(1)), 5'($urandom), $urandom, 1'($urandom_range(1)), $urandom);
      end
      for (int k = 0; k < NWB; k++)
        if ($urandom_range(1) == 1) begin
          if (mq.size() > 0 && $urandom_range(3) != 0) wb(k, mq[$urandom_range(mq.size() - 1)].id, $urandom);
          else wb(k, $urandom_range(DEPTH - 1), $urandom);
        end
      rob.q_id1 = 4'($urandom);
      rob.q_id2 = 4'($urandom);
      step();
    end
    rst = 1'b0; rdy = 1'b1; idle();
    repeat (DEPTH + 4) begin
      for (int i = 0; i < mq.size(); i++) if (!mq[i].rdy) begin wb(0, mq[i].id, 32'h0); break; end
      step(); idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
